// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Memory stage of a 5-stage ARM-style pipeline. Holds the EX/MEM pipeline
//   register, drives the data-memory bus through a variable-latency req/ack
//   handshake, stalls the upstream stages while an access is outstanding, and
//   loads the MEM/WB register every cycle. A watchdog turns a bus access that
//   never acknowledges into a flagged retirement with its write-back
//   suppressed.
//
// Parameters
//   DATA_W  : data / address width
//   TMO_CYC : cycles of an access without ack before it is abandoned (1..255)
//
// Compile-time option
//   MEM_ALIGN_CHECK_EN : when defined, a load/store whose address has non-zero
//     low two bits never reaches the bus; it retires in one cycle with
//     write-back disabled and raises bus_error_out. When undefined the low
//     address bits are forced to zero and the access proceeds normally.
//
// Ports
//   clk, reset (async, active-low)
//   enable, flush                   : hazard-unit control of the EX/MEM capture
//   *_in_exmem                      : instruction fields arriving from EX
//   dmem_req/we/addr/wdata (out)    : data-memory request
//   dmem_rdata/ack (in)             : data-memory response
//   mem_stall_out                   : freezes IF/ID/EX and EX/MEM
//   *_out_memwb                     : MEM/WB register contents
//   fwd_Rd_out/fwd_data_out/fwd_we_out : EX/MEM view for the forwarding unit
//   bus_error_out                   : one-cycle pulse, aligned with the
//                                     retirement of the failed access in MEM/WB
//   dbg_state_out                   : current handshake state (0 IDLE, 1 WAIT)
//
// Handshake: the stage holds dmem_req high with we/addr/wdata stable from the
// first cycle of an access until the cycle in which dmem_ack is seen high;
// the access completes in exactly that cycle (ack may arrive in the same cycle
// req first rises). dmem_rdata is only sampled in the ack cycle.
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              flush,
  input  logic [DATA_W-1:0] pc_in_exmem,
  input  logic [DATA_W-1:0] alu_result_in_exmem,
  input  logic [DATA_W-1:0] write_data_in_exmem,
  input  logic [3:0]        Rd_in_exmem,
  input  logic              reg_write_en_in_exmem,
  input  logic              mem_read_en_in_exmem,
  input  logic              mem_write_en_in_exmem,
  input  logic              mem_to_reg_in_exmem,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall_out,
  output logic [DATA_W-1:0] pc_out_memwb,
  output logic [DATA_W-1:0] alu_result_out_memwb,
  output logic [DATA_W-1:0] read_data_out_memwb,
  output logic [3:0]        Rd_out_memwb,
  output logic              reg_write_en_out_memwb,
  output logic              mem_to_reg_out_memwb,
  output logic [3:0]        fwd_Rd_out,
  output logic [DATA_W-1:0] fwd_data_out,
  output logic              fwd_we_out,
  output logic              bus_error_out,
  output logic              dbg_state_out
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // Counter value at which an unacknowledged access is abandoned. The counter
  // holds the number of cycles the current access has already spent waiting,
  // so the access gets TMO_CYC-1 stall cycles before the timeout cycle.
  localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

  // EX/MEM register
  logic              r_valid;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_alu;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_rd;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_mem_to_reg;

  // Handshake state
  state_t            r_state;
  state_t            w_state_nxt;
  logic [7:0]        r_tmo_cnt;
  logic [7:0]        w_tmo_cnt_nxt;

  // MEM/WB register
  logic [DATA_W-1:0] r_wb_pc;
  logic [DATA_W-1:0] r_wb_alu;
  logic [DATA_W-1:0] r_wb_rdata;
  logic [3:0]        r_wb_rd;
  logic              r_wb_reg_write;
  logic              r_wb_mem_to_reg;
  logic              r_bus_error;

  // Decode of the instruction held in EX/MEM
  logic w_memop;
  logic w_misalign;
  logic w_bus_op;
  logic w_is_load;
  logic w_timeout;
  logic w_stall;

  assign w_memop = r_valid & (r_mem_read | r_mem_write);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = w_memop & (r_alu[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Only an access that passes the alignment filter goes to the bus.
  assign w_bus_op  = w_memop & ~w_misalign;
  // Read and write both set behaves as a store.
  assign w_is_load = r_mem_read & ~r_mem_write;
  // An ack in the timeout cycle wins: the access completes normally.
  assign w_timeout = w_bus_op & ~dmem_ack & (r_tmo_cnt == TMO_LAST);
  assign w_stall   = w_bus_op & ~dmem_ack & ~w_timeout;

  // ---------------------------------------------------------------------------
  // Handshake FSM: next state and watchdog counter
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_tmo_cnt_nxt = r_tmo_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_stall) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Leaves on ack or timeout, both of which remove the stall.
        if (!w_stall) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // The issue cycle counts as the first waiting cycle, so the counter is
    // already 1 when the FSM enters WAIT.
    if (w_stall) begin
      w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
    end else begin
      w_tmo_cnt_nxt = 8'd0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_tmo_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_tmo_cnt <= w_tmo_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // EX/MEM register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_alu        <= '0;
      r_wdata      <= '0;
      r_rd         <= 4'd0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (enable && !w_stall) begin
      if (flush) begin
        // Bubble: fields zeroed so it is invisible downstream.
        r_valid      <= 1'b0;
        r_pc         <= '0;
        r_alu        <= '0;
        r_wdata      <= '0;
        r_rd         <= 4'd0;
        r_reg_write  <= 1'b0;
        r_mem_read   <= 1'b0;
        r_mem_write  <= 1'b0;
        r_mem_to_reg <= 1'b0;
      end else begin
        r_valid      <= 1'b1;
        r_pc         <= pc_in_exmem;
        r_alu        <= alu_result_in_exmem;
        r_wdata      <= write_data_in_exmem;
        r_rd         <= Rd_in_exmem;
        r_reg_write  <= reg_write_en_in_exmem;
        r_mem_read   <= mem_read_en_in_exmem;
        r_mem_write  <= mem_write_en_in_exmem;
        r_mem_to_reg <= mem_to_reg_in_exmem;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB register: loaded every cycle; a stalled cycle inserts a bubble.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb_pc         <= '0;
      r_wb_alu        <= '0;
      r_wb_rdata      <= '0;
      r_wb_rd         <= 4'd0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_bus_error     <= 1'b0;
    end else if (w_stall) begin
      r_wb_pc         <= '0;
      r_wb_alu        <= '0;
      r_wb_rdata      <= '0;
      r_wb_rd         <= 4'd0;
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_bus_error     <= 1'b0;
    end else begin
      r_wb_pc         <= r_pc;
      r_wb_alu        <= r_alu;
      r_wb_rd         <= r_rd;
      r_wb_mem_to_reg <= r_mem_to_reg;
      // A failed access must not write the register file.
      r_wb_reg_write  <= r_reg_write & ~w_timeout & ~w_misalign;
      // Unstalled with a bus op means either ack or timeout; only the
      // acknowledged load returns data.
      r_wb_rdata      <= (w_bus_op && w_is_load && dmem_ack) ? dmem_rdata : '0;
      r_bus_error     <= w_timeout | w_misalign;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Request is purely a function of EX/MEM, so an async reset drops it at once.
  assign dmem_req      = w_bus_op;
  assign dmem_we       = r_mem_write;
  assign dmem_addr     = {r_alu[DATA_W-1:2], 2'b00};
  assign dmem_wdata    = r_wdata;
  assign mem_stall_out = w_stall;

  assign pc_out_memwb           = r_wb_pc;
  assign alu_result_out_memwb   = r_wb_alu;
  assign read_data_out_memwb    = r_wb_rdata;
  assign Rd_out_memwb           = r_wb_rd;
  assign reg_write_en_out_memwb = r_wb_reg_write;
  assign mem_to_reg_out_memwb   = r_wb_mem_to_reg;
  assign bus_error_out          = r_bus_error;

  // Load results are not yet available here; the hazard unit covers load-use.
  assign fwd_Rd_out    = r_rd;
  assign fwd_data_out  = r_alu;
  assign fwd_we_out    = r_valid & r_reg_write & ~r_mem_read;

  assign dbg_state_out = r_state;

endmodule
